// File: rtl/hazard_ctrl_if.sv
// ID-stage <-> hazard controller signal bundle: the decoded instruction's
// register usage goes in; issue/stall, forwarding selects and scoreboard
// status come back.
interface hazard_ctrl_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 2
) ();
    logic          issue_valid_i;
    logic [AW-1:0] rs1_i;
    logic [AW-1:0] rs2_i;
    logic          rs1_used_i;
    logic          rs2_used_i;
    logic [AW-1:0] rd_i;
    logic          rd_write_i;
    logic          rd_late_i;
    logic          flush_i;

    logic             issue_o;
    logic             stall_o;
    logic [2:0]       fwd_a_o;
    logic [2:0]       fwd_b_o;
    logic [DEPTH-1:0] inflight_o;
    logic [15:0]      stall_cnt_o;

    // Decode side: presents the instruction, consumes the decision.
    modport master (
        output issue_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
               rd_i, rd_write_i, rd_late_i, flush_i,
        input  issue_o, stall_o, fwd_a_o, fwd_b_o, inflight_o, stall_cnt_o
    );

    // Hazard controller side.
    modport slave (
        input  issue_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
               rd_i, rd_write_i, rd_late_i, flush_i,
        output issue_o, stall_o, fwd_a_o, fwd_b_o, inflight_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the in-order rv32i pipeline.
// A shift-register scoreboard tracks destination writes in flight from EX
// (stage 1) to WB (stage DEPTH); the ID instruction is issued with
// per-operand forwarding selects or stalled on an unresolved RAW hazard.
module hazard_ctrl #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned AW         = 5,
    parameter int unsigned LATE_STAGE = 2,
    parameter int unsigned FWD_EN     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave hif
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          wr;
        logic          late;
    } entry_t;

    entry_t sb [1:DEPTH];

    logic       found_a, found_b;
    logic       rdy_a, rdy_b;
    logic [2:0] k_a, k_b;
    logic       haz_a, haz_b;
    logic       go;
    logic [15:0] stall_cnt;

    // True when entry e will write source s that the instruction actually reads.
    function automatic logic hit(input entry_t e, input logic [AW-1:0] s, input logic used);
        return e.valid && e.wr && (e.rd == s) && (s != '0) && used;
    endfunction

    // Youngest (lowest stage) matching entry per operand, and whether its result is available yet.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        rdy_a   = 1'b0;
        rdy_b   = 1'b0;
        k_a     = '0;
        k_b     = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (!found_a && hit(sb[k], hif.rs1_i, hif.rs1_used_i)) begin
                found_a = 1'b1;
                k_a     = 3'(k);
                rdy_a   = !sb[k].late || (k >= LATE_STAGE);
            end
            if (!found_b && hit(sb[k], hif.rs2_i, hif.rs2_used_i)) begin
                found_b = 1'b1;
                k_b     = 3'(k);
                rdy_b   = !sb[k].late || (k >= LATE_STAGE);
            end
        end
    end

    // Issue/stall decision and forwarding selects; selects are zero unless issuing.
    always_comb begin
        if (FWD_EN != 0) begin
            haz_a = found_a && !rdy_a;
            haz_b = found_b && !rdy_b;
        end else begin
            haz_a = found_a;
            haz_b = found_b;
        end
        go          = hif.issue_valid_i && !hif.flush_i;
        hif.issue_o = go && !(haz_a || haz_b);
        hif.stall_o = go && (haz_a || haz_b);
        hif.fwd_a_o = '0;
        hif.fwd_b_o = '0;
        if (FWD_EN != 0 && hif.issue_o) begin
            if (found_a) hif.fwd_a_o = k_a;
            if (found_b) hif.fwd_b_o = k_b;
        end
    end

    // Scoreboard status and stall counter exposed to the pipeline.
    always_comb begin
        hif.inflight_o = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            hif.inflight_o[k-1] = sb[k].valid;
        end
        hif.stall_cnt_o = stall_cnt;
    end

    // Scoreboard shifts every cycle; stage 1 takes the issued instruction or a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            if (hif.issue_o) begin
                sb[1] <= '{valid: 1'b1, rd: hif.rd_i, wr: hif.rd_write_i, late: hif.rd_late_i};
            end else begin
                sb[1] <= '0;
            end
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Saturating count of stall cycles since reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (hif.stall_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a non-forwarding instance
// share one directed stimulus; a history-based model predicts both every cycle,
// and literal checks pin the key scenarios.
module tb_hazard_ctrl;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned LATE  = 2;
    localparam int          MAXC  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv = 1'b0, r1u = 1'b0, r2u = 1'b0, rdw = 1'b0, lt = 1'b0, fl = 1'b0;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    hazard_ctrl_if #(.AW(AW), .DEPTH(DEPTH)) ifa ();
    hazard_ctrl_if #(.AW(AW), .DEPTH(DEPTH)) ifb ();

    assign ifa.issue_valid_i = iv;  assign ifb.issue_valid_i = iv;
    assign ifa.rs1_i         = rs1; assign ifb.rs1_i         = rs1;
    assign ifa.rs2_i         = rs2; assign ifb.rs2_i         = rs2;
    assign ifa.rs1_used_i    = r1u; assign ifb.rs1_used_i    = r1u;
    assign ifa.rs2_used_i    = r2u; assign ifb.rs2_used_i    = r2u;
    assign ifa.rd_i          = rd;  assign ifb.rd_i          = rd;
    assign ifa.rd_write_i    = rdw; assign ifb.rd_write_i    = rdw;
    assign ifa.rd_late_i     = lt;  assign ifb.rd_late_i     = lt;
    assign ifa.flush_i       = fl;  assign ifb.flush_i       = fl;

    hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .LATE_STAGE(LATE), .FWD_EN(1)) u_fwd (
        .clk_i(clk), .rst_i(rst), .hif(ifa));
    hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .LATE_STAGE(LATE), .FWD_EN(0)) u_nofwd (
        .clk_i(clk), .rst_i(rst), .hif(ifb));

    always #5 clk = ~clk;

    logic             a_iss [2];
    logic             a_stl [2];
    logic [2:0]       a_fa  [2];
    logic [2:0]       a_fb  [2];
    logic [DEPTH-1:0] a_inf [2];
    logic [15:0]      a_cnt [2];
    assign a_iss[0] = ifa.issue_o;     assign a_iss[1] = ifb.issue_o;
    assign a_stl[0] = ifa.stall_o;     assign a_stl[1] = ifb.stall_o;
    assign a_fa[0]  = ifa.fwd_a_o;     assign a_fa[1]  = ifb.fwd_a_o;
    assign a_fb[0]  = ifa.fwd_b_o;     assign a_fb[1]  = ifb.fwd_b_o;
    assign a_inf[0] = ifa.inflight_o;  assign a_inf[1] = ifb.inflight_o;
    assign a_cnt[0] = ifa.stall_cnt_o; assign a_cnt[1] = ifb.stall_cnt_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: record of what each instance issued at every clock edge. An
    // instruction issued at edge i sits in stage n-i+1 after edge n, unless
    // a reset edge came at or after i.
    int   fen [2] = '{1, 0};
    logic rv  [2][MAXC];
    logic [AW-1:0] rrd [2][MAXC];
    logic rwr [2][MAXC];
    logic rlt [2][MAXC];
    int   n = 0;
    int   rst_edge [2] = '{0, 0};
    int   mcnt [2] = '{0, 0};
    logic e_iss [2] = '{1'b0, 1'b0};
    logic e_stl [2] = '{1'b0, 1'b0};

    function automatic logic alive(input int i, input int idx);
        return (idx >= 1) && (idx > rst_edge[i]) && rv[i][idx];
    endfunction

    task automatic young(input int i, input logic [AW-1:0] s, input logic used,
                         output logic f, output int kk, output logic rdy);
        int idx;
        f = 1'b0; kk = 0; rdy = 1'b0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            idx = n - k + 1;
            if (!f && alive(i, idx) && rwr[i][idx] && rrd[i][idx] == s && s != '0 && used) begin
                f   = 1'b1;
                kk  = k;
                rdy = !rlt[i][idx] || (k >= int'(LATE));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic fa_f, fb_f, ra, rb, ha, hb, go;
            int ka, kb;
            logic [2:0] efa, efb;
            logic [DEPTH-1:0] einf;
            young(i, rs1, r1u, fa_f, ka, ra);
            young(i, rs2, r2u, fb_f, kb, rb);
            ha = (fen[i] != 0) ? (fa_f && !ra) : fa_f;
            hb = (fen[i] != 0) ? (fb_f && !rb) : fb_f;
            go = iv && !fl;
            e_iss[i] = go && !(ha || hb);
            e_stl[i] = go && (ha || hb);
            efa = (e_iss[i] && fen[i] != 0 && fa_f) ? 3'(ka) : 3'd0;
            efb = (e_iss[i] && fen[i] != 0 && fb_f) ? 3'(kb) : 3'd0;
            for (int k = 1; k <= int'(DEPTH); k++) einf[k-1] = alive(i, n - k + 1);
            if (chk_on) begin
                chk($sformatf("issue[%0d]", i),    32'(a_iss[i]), 32'(e_iss[i]));
                chk($sformatf("stall[%0d]", i),    32'(a_stl[i]), 32'(e_stl[i]));
                chk($sformatf("fwd_a[%0d]", i),    32'(a_fa[i]),  32'(efa));
                chk($sformatf("fwd_b[%0d]", i),    32'(a_fb[i]),  32'(efb));
                chk($sformatf("inflight[%0d]", i), 32'(a_inf[i]), 32'(einf));
                chk($sformatf("stall_cnt[%0d]", i), 32'(a_cnt[i]), 32'(mcnt[i]));
            end
        end
    end

    always @(posedge clk) begin
        n = n + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rst_edge[i] = n;
                rv[i][n]    = 1'b0;
                mcnt[i]     = 0;
            end else begin
                rv[i][n]  = e_iss[i];
                rrd[i][n] = rd;
                rwr[i][n] = rdw;
                rlt[i][n] = lt;
                if (e_stl[i] && mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
            end
        end
    end

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic au,
                         input logic [AW-1:0] b, input logic bu,
                         input logic [AW-1:0] d, input logic dw, input logic dl, input logic f);
        iv = v; rs1 = a; r1u = au; rs2 = b; r2u = bu; rd = d; rdw = dw; lt = dl; fl = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_inflight_a", 32'(a_inf[0]), 32'h0);
        chk("rst_cnt_b",      32'(a_cnt[1]), 32'h0);
        chk("rst_stall_a",    32'(a_stl[0]), 32'h0);

        // Empty scoreboard: issue follows valid, no forwarding
        drive(1, 5, 1, 6, 1, 8, 1, 0, 0);
        @(negedge clk);
        chk("empty_issue_b", 32'(a_iss[1]), 32'h1);
        chk("empty_fwd_a",   32'(a_fa[0]),  32'h0);
        tick();
        drain();

        // No forwarding: reader of x4 waits until the write retires
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
        tick();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("nofwd_stall1", 32'(a_stl[1]), 32'h1);
        chk("fwd_inst_fa1", 32'(a_fa[0]),  32'h1);
        tick();
        @(negedge clk);
        chk("nofwd_stall2", 32'(a_stl[1]), 32'h1);
        tick();
        @(negedge clk);
        chk("nofwd_issue",  32'(a_iss[1]), 32'h1);
        chk("nofwd_fa",     32'(a_fa[1]),  32'h0);
        chk("nofwd_cnt",    32'(a_cnt[1]), 32'h2);
        tick();
        drain();

        // Back-to-back ALU RAW
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        @(negedge clk);
        chk("alu_issue0", 32'(a_iss[0]), 32'h1);
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        @(negedge clk);
        chk("alu_issue1", 32'(a_iss[0]), 32'h1);
        chk("alu_fa1",    32'(a_fa[0]),  32'h1);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_fa2",    32'(a_fa[0]),  32'h2);
        tick();
        drain();

        // Load-use
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall", 32'(a_stl[0]), 32'h1);
        chk("lu_noiss", 32'(a_iss[0]), 32'h0);
        tick();
        @(negedge clk);
        chk("lu_issue", 32'(a_iss[0]), 32'h1);
        chk("lu_fb",    32'(a_fb[0]),  32'h2);
        chk("lu_cnt",   32'(a_cnt[0]), 32'h1);
        tick();
        drain();

        // x0 never hazards; rd == rs of the same instruction is ignored
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0, 12, 1, 0, 0);
        @(negedge clk);
        chk("x0_stall_a", 32'(a_stl[0]), 32'h0);
        chk("x0_stall_b", 32'(a_stl[1]), 32'h0);
        chk("x0_fa",      32'(a_fa[0]),  32'h0);
        tick();
        drive(1, 13, 1, 0, 0, 13, 1, 0, 0);
        @(negedge clk);
        chk("self_rd_iss", 32'(a_iss[1]), 32'h1);
        tick();
        drain();

        // Unused operand ignored
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("unused_stall_b", 32'(a_stl[1]), 32'h0);
        chk("unused_fb",      32'(a_fb[0]),  32'h0);
        tick();
        drain();

        // rs1 == rs2 both forwarded from the same stage
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
        tick();
        drive(1, 9, 1, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("same_fa", 32'(a_fa[0]), 32'h1);
        chk("same_fb", 32'(a_fb[0]), 32'h1);
        tick();
        drain();

        // Youngest match wins
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("young_fa", 32'(a_fa[0]), 32'h1);
        tick();
        drain();

        // Flush during load-use, then reset with a full scoreboard
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 1);
        @(negedge clk);
        chk("flush_iss",   32'(a_iss[0]), 32'h0);
        chk("flush_stall", 32'(a_stl[0]), 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("flush_inflight", 32'(a_inf[0]), 32'h2);
        tick();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_inflight", 32'(a_inf[0]), 32'h3);
        tick();
        rst = 1'b0;
        drive(1, 2, 1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_inflight", 32'(a_inf[0]), 32'h0);
        chk("post_rst_cnt_a",    32'(a_cnt[0]), 32'h0);
        chk("post_rst_iss_b",    32'(a_iss[1]), 32'h1);
        chk("post_rst_fa",       32'(a_fa[0]),  32'h0);
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order rv32i pipeline. It keeps a scoreboard of in-flight destination-register writes for the stages between decode and regfile write-back. For each decoded instruction it either issues it with per-operand forwarding selects, or stalls it on an unresolved RAW hazard. It sits beside idstage, gating the ID→EX hand-off; exstage uses its forwarding selects to choose operand sources. Depth, address width, late-result stage and forwarding enable are parameters, so the same block serves deeper or non-forwarding pipeline variants.

Parameters:
DEPTH, 2, number of in-flight stages after ID (stage 1 = EX … stage DEPTH = WB); legal range 1..7
AW, 5, register address width (4 for RV32E)
LATE_STAGE, 2, first stage index at which a late (load-type) result is forwardable; 1..DEPTH
FWD_EN, 1, 1 = forward from in-flight stages; 0 = stall on any match until the entry retires

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  ID holds a valid instruction
rs1_i  in  AW  source register 1 of ID instruction
rs2_i  in  AW  source register 2
rs1_used_i  in  1  rs1 is read by the instruction
rs2_used_i  in  1  rs2 is read
rd_i  in  AW  destination register
rd_write_i  in  1  instruction writes rd
rd_late_i  in  1  result is produced late (load); forwardable only from LATE_STAGE on
flush_i  in  1  kill the ID instruction this cycle (taken branch/jump)
issue_o  out  1  ID instruction advances to EX at this clock edge
stall_o  out  1  ID instruction held this cycle
fwd_a_o  out  3  rs1 source: 0 = regfile, k = stage k result
fwd_b_o  out  3  rs2 source, same encoding
inflight_o  out  DEPTH  valid bit of each scoreboard entry, bit k-1 = stage k
stall_cnt_o  out  16  number of stall cycles since reset, saturating

Behaviour:
- Scoreboard: entries e[1..DEPTH], each {valid, rd, wr, late}. All registers are cleared on rst_i. Entries always advance at each clock edge: e[k+1] <= e[k]; e[DEPTH] retires.
- e[1] loads {1, rd_i, rd_write_i, rd_late_i} when issue_o = 1; otherwise it loads a bubble (valid = 0).
- Match for source s against e[k]: valid & wr & rd == s & s != 0 & s_used. x0 never hazards.
- Only the youngest match (lowest k) per operand is considered.
  - It is ready if !late or k >= LATE_STAGE.
- Hazard per operand:
  - FWD_EN = 1: the youngest match exists and is not ready. If it exists and is ready, fwd = k.
  - FWD_EN = 0: any match is a hazard; fwd is always 0.
  - No match: fwd = 0.
- Combinational outputs:
  - hazard = hazA | hazB.
  - issue_o = issue_valid_i & !flush_i & !hazard.
  - stall_o = issue_valid_i & !flush_i & hazard.
  - flush_i has priority over hazard: it gives issue_o = 0 and stall_o = 0, and inserts a bubble.
- fwd_a_o / fwd_b_o are valid only when issue_o = 1. They are driven 0 when issue_valid_i = 0 or flush_i = 1.
- Regfile write at stage DEPTH is not bypassed inside regfile. A match at stage DEPTH is therefore forwarded (fwd = DEPTH).
- stall_cnt_o increments by 1 on each cycle with stall_o = 1 and holds at 16'hFFFF.
- Reset values:
  - inflight_o = 0 and stall_cnt_o = 0.
  - With the scoreboard cleared, stall_o = 0, fwd_a_o = fwd_b_o = 0, and issue_o = issue_valid_i & !flush_i.
- Reset mid-operation: all in-flight entries are dropped at the reset edge; no forward or stall references them afterwards.
- Simultaneous rs1 == rs2 matching: both selects carry the same k.
- Same instruction with rd == rs: the match is against older entries only; the ID instruction's own rd is ignored.
- Upper bits of fwd_*_o beyond $clog2(DEPTH+1) are 0.

Test Plan:
- Back-to-back ALU RAW, defaults: issue add x5 (rd = 5, wr = 1), next cycle rs1 = 5 -> issue_o = 1, stall_o = 0, fwd_a_o = 1; one cycle later a reader of x5 gets fwd_a_o = 2.
- Load-use, defaults: issue rd = 7, late = 1, then rs2 = 7 -> stall_o = 1 for one cycle, then issue_o = 1 with fwd_b_o = 2; stall_cnt_o = 1.
- x0 and unused operands: in-flight rd = 0, wr = 1 and ID rs1 = 0; or rs2 = 5 with rs2_used_i = 0 against in-flight rd = 5 -> no stall, fwd = 0.
- Youngest wins: e[2].rd = 3 and e[1].rd = 3 (both ALU), ID rs1 = 3 -> fwd_a_o = 1.
- FWD_EN = 0, DEPTH = 2: issue rd = 4, then rs1 = 4 -> stall_o = 1 for exactly 2 cycles, then issue_o = 1 with fwd_a_o = 0; stall_cnt_o = 2.
- Flush during stall: load-use condition with flush_i = 1 -> issue_o = 0, stall_o = 0, next inflight_o bit0 = 0. Assert rst_i with inflight_o = 2'b11 -> inflight_o = 0 and stall_cnt_o = 0 after the edge.
